// File: rtl/frame_capture.sv
// frame_capture: captures RGB565 byte pairs from a DVP-style camera and writes
// one 4-bit grayscale pixel per completed pair into a frame buffer.
//
// Optional feature: define FRAME_CAPTURE_CROP_EN to write only the centre
// window 20<=x<620, 40<=y<440. Addresses remain full-frame.
//
// Ports:
//   pixel_clk   camera PCLK; all logic runs on its rising edge
//   rst_n       asynchronous active-low reset
//   capture_en  level that arms continuous frame capture
//   cam_vsync   high during vertical blanking
//   cam_href    high while line bytes are valid
//   cam_data    RGB565 byte stream, high byte first
//   wr_en       one-cycle frame-buffer write strobe
//   wr_addr     write address y*H_ACTIVE+x
//   wr_data     grayscale pixel
//   frame_done  one-cycle pulse: frame ended with exactly V_ACTIVE lines
//   frame_err   one-cycle pulse: frame ended with any other line count
//   busy        high whenever the controller is not idle
module frame_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [3:0]  wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned SUM_W  = 6;
  // x saturates at H_ACTIVE; y saturates one past V_ACTIVE so an
  // over-long frame still reads as a line-count error.
  localparam int unsigned X_W    = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W    = $clog2(V_ACTIVE + 2);

  localparam logic [X_W-1:0]    X_LIM     = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    Y_SAT     = Y_W'(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

`ifdef FRAME_CAPTURE_CROP_EN
  localparam int unsigned CROP_X0 = 20;
  localparam int unsigned CROP_X1 = 620;
  localparam int unsigned CROP_Y0 = 40;
  localparam int unsigned CROP_Y1 = 440;
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    WAIT_START = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   frame_end;

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              phase_q;
  logic              href_q;
  logic [7:0]        hi_q;

  logic [4:0]        r5;
  logic [5:0]        g6;
  logic [4:0]        b5;
  logic [SUM_W-1:0]  gray_sum;
  logic [ADDR_W-1:0] pix_addr;
  logic              in_range;
  logic              write_ok;

  // State register
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a vsync high seen in ACTIVE is the rising edge that
  // closes the frame, since ACTIVE is only entered with vsync low.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE:       if (capture_en) state_d = WAIT_BLANK;
      WAIT_BLANK: if (cam_vsync)  state_d = WAIT_START;
      WAIT_START: if (!cam_vsync) state_d = ACTIVE;
      ACTIVE: begin
        if (cam_vsync) begin
          frame_end = 1'b1;
          state_d   = capture_en ? WAIT_START : IDLE;
        end
      end
      default:    state_d = IDLE;
    endcase
  end

  // RGB565 unpack: high byte held from the even phase, low byte live
  assign r5 = hi_q[7:3];
  assign g6 = {hi_q[2:0], cam_data[7:5]};
  assign b5 = cam_data[4:0];

  // (R[4:1] + 2*G[5:2] + B[4:1]) in 6 bits; max 60, the top 4 bits are gray
  assign gray_sum = SUM_W'(r5 >> 1) + SUM_W'((g6 >> 2) << 1) + SUM_W'(b5 >> 1);

  assign pix_addr = line_base_q + ADDR_W'(x_q);
  assign in_range = (x_q < X_LIM) && (y_q < Y_LIM);

`ifdef FRAME_CAPTURE_CROP_EN
  assign write_ok = in_range
                    && (32'(x_q) >= CROP_X0) && (32'(x_q) < CROP_X1)
                    && (32'(y_q) >= CROP_Y0) && (32'(y_q) < CROP_Y1);
`else
  assign write_ok = in_range;
`endif

  // Pixel assembly, counters and registered outputs
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      phase_q     <= 1'b0;
      href_q      <= 1'b0;
      hi_q        <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= frame_end && (y_q == Y_LIM);
      frame_err  <= frame_end && (y_q != Y_LIM);
      busy       <= (state_d != IDLE);

      if ((state_q != ACTIVE) || frame_end) begin
        // Counters start every frame from the origin
        x_q         <= '0;
        y_q         <= '0;
        line_base_q <= '0;
        phase_q     <= 1'b0;
        href_q      <= 1'b0;
      end else begin
        href_q <= cam_href;
        if (cam_href) begin
          if (!phase_q) begin
            hi_q    <= cam_data;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (write_ok) begin
              wr_en   <= 1'b1;
              wr_addr <= pix_addr;
              wr_data <= gray_sum[SUM_W-1 -: PIX_W];
            end
            if (x_q < X_LIM) begin
              x_q <= x_q + X_W'(1);
            end
          end
        end else if (href_q) begin
          // Line end: a dangling high byte is dropped
          phase_q <= 1'b0;
          x_q     <= '0;
          if ((x_q != '0) && (y_q < Y_SAT)) begin
            y_q         <= y_q + Y_W'(1);
            line_base_q <= line_base_q + LINE_STEP;
          end
        end
      end
    end
  end

endmodule
